fifo_read_ctrl: RTL and testbench

- Read-side controller for the parameterized async FIFO; the consumer of the dual-clock memory's combinational read port.
- Synchronizes the write-domain Gray pointer into the read clock domain.
- Owns the binary and Gray read pointers and generates empty, occupancy and almost-empty status.
- Presents data through a registered first-word-fall-through valid/ready output stage.

---
 rtl/fifo_read_ctrl.sv | 91 +++++++++
 tb/tb_fifo_read_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read side of the dual-clock FIFO.
// Syncs the write Gray pointer, owns read pointers, FWFT output reg.
module fifo_read_ctrl #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [PTR_WIDTH:0]    g_wptr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  out_ready,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    fill
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AE  = PW'(AE_THRESH);
  localparam logic [PW-1:0] ONE = PW'(1);

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must equal 2**PTR_WIDTH");
  end

  logic [PW-1:0] s1;
  logic [PW-1:0] g_wptr_s;
  logic [PW-1:0] b_wptr_s;
  logic [PW-1:0] b_rptr_nx;
  logic          pop;

  function automatic logic [PW-1:0] gray2bin(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(
    input logic [PW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // two-flop synchronizer, nothing ahead of the second stage
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      s1       <= '0;
      g_wptr_s <= '0;
    end else begin
      s1       <= g_wptr;
      g_wptr_s <= s1;
    end
  end

  // status and fetch decision from registered state only
  always_comb begin
    b_wptr_s     = gray2bin(g_wptr_s);
    fill         = b_wptr_s - b_rptr;
    empty        = (g_rptr == g_wptr_s);
    almost_empty = (fill <= AE);
    pop          = !empty && (!out_valid || out_ready);
    b_rptr_nx    = b_rptr + ONE;
  end

  // fetch into the output reg on pop, drop valid when drained
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      b_rptr    <= '0;
      g_rptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= mem_data;
      out_valid <= 1'b1;
      b_rptr    <= b_rptr_nx;
      g_rptr    <= bin2gray(b_rptr_nx);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed vectors for the FIFO read controller.
// Memory is a bench array addressed by the DUT's b_rptr.
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] g_wptr;
  logic [7:0] mem_data;
  logic       out_ready;
  logic [4:0] b_rptr;
  logic [4:0] g_rptr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] fill;

  logic [7:0] mem [16];
  int nvec = 0;
  int nerr = 0;

  assign mem_data = mem[b_rptr[3:0]];

  always #5 rclk = ~rclk;

  fifo_read_ctrl #(
    .DEPTH(16), .DATA_WIDTH(8),
    .PTR_WIDTH(4), .AE_THRESH(2)
  ) dut (
    .rclk(rclk), .rrst(rrst),
    .g_wptr(g_wptr), .mem_data(mem_data),
    .out_ready(out_ready), .b_rptr(b_rptr),
    .g_rptr(g_rptr), .out_data(out_data),
    .out_valid(out_valid), .empty(empty),
    .almost_empty(almost_empty), .fill(fill)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    g_wptr = 5'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rrst = 1'b0;
  endtask

  // backpressure table: ready per edge, expected after that edge
  logic       bp_r [9] = '{1,0,0,1,0,1,1,1,1};
  logic [7:0] bp_d [9] = '{8'h50,8'h50,8'h50,8'h51,8'h51,
                           8'h52,8'h53,8'h54,8'h54};
  logic [4:0] bp_f [9] = '{4,4,4,3,3,2,1,0,0};
  logic       bp_v [9] = '{1,1,1,1,1,1,1,1,0};

  // wrap table: after each of four pops starting at b_rptr=30
  logic [4:0] wr_b  [4] = '{5'd31, 5'd0, 5'd1, 5'd2};
  logic [4:0] wr_g  [4] = '{5'b10000, 5'b00000,
                            5'b00001, 5'b00011};
  logic [7:0] wr_d  [4] = '{8'h3E, 8'h3F, 8'h30, 8'h31};
  logic [4:0] wr_f  [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
  logic       wr_ae [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic       wr_em [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // streaming: Gray codes of 1..16
  logic [4:0] st_g [16] = '{
    5'b00001, 5'b00011, 5'b00010, 5'b00110,
    5'b00111, 5'b00101, 5'b00100, 5'b01100,
    5'b01101, 5'b01111, 5'b01110, 5'b01010,
    5'b01011, 5'b01001, 5'b01000, 5'b11000
  };

  initial begin
    logic [4:0] prev_g;
    bit         hit;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rrst = 1'b1;
    g_wptr = 5'd0;
    out_ready = 1'b0;
    #12;

    // reset state
    check("rst_b_rptr", b_rptr, 0);
    check("rst_g_rptr", g_rptr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_empty", empty, 1);
    check("rst_fill", fill, 0);
    check("rst_ae", almost_empty, 1);

    // single word, 3-edge latency then hold then drain
    rrst = 1'b0;
    mem[0] = 8'hA5;
    g_wptr = 5'd1;
    tick();
    check("sw_e1_valid", out_valid, 0);
    check("sw_e1_empty", empty, 1);
    tick();
    check("sw_e2_valid", out_valid, 0);
    check("sw_e2_fill", fill, 1);
    check("sw_e2_empty", empty, 0);
    tick();
    check("sw_e3_valid", out_valid, 1);
    check("sw_e3_data", out_data, 8'hA5);
    check("sw_e3_b", b_rptr, 1);
    check("sw_e3_g", g_rptr, 1);
    check("sw_e3_fill", fill, 0);
    check("sw_e3_empty", empty, 1);
    tick();
    tick();
    check("sw_hold_valid", out_valid, 1);
    check("sw_hold_data", out_data, 8'hA5);
    check("sw_hold_b", b_rptr, 1);
    out_ready = 1'b1;
    tick();
    check("sw_drain_valid", out_valid, 0);
    check("sw_drain_data", out_data, 8'hA5);
    check("sw_drain_b", b_rptr, 1);
    tick();
    check("sw_idle_valid", out_valid, 0);
    check("sw_idle_b", b_rptr, 1);

    // reset with a word held in the output reg
    out_ready = 1'b0;
    mem[1] = 8'h5C;
    g_wptr = 5'b00011;
    tick();
    tick();
    tick();
    check("mr_pre_valid", out_valid, 1);
    check("mr_pre_data", out_data, 8'h5C);
    rrst = 1'b1;
    g_wptr = 5'd0;
    #1;
    check("mr_b_rptr", b_rptr, 0);
    check("mr_g_rptr", g_rptr, 0);
    check("mr_valid", out_valid, 0);
    check("mr_empty", empty, 1);
    check("mr_fill", fill, 0);
    check("mr_ae", almost_empty, 1);
    do_reset();

    // streaming 16 words at full rate
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
    g_wptr = 5'b11000;
    out_ready = 1'b1;
    tick();
    tick();
    check("st_fill16", fill, 16);
    check("st_empty0", empty, 0);
    check("st_ae0", almost_empty, 0);
    prev_g = g_rptr;
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("st_valid%0d", k), out_valid, 1);
      check($sformatf("st_data%0d", k), out_data,
            8'h30 + 8'(k));
      check($sformatf("st_b%0d", k), b_rptr, k + 1);
      check($sformatf("st_g%0d", k), g_rptr, st_g[k]);
      check($sformatf("st_1bit%0d", k),
            $countones(g_rptr ^ prev_g), 1);
      prev_g = g_rptr;
    end
    check("st_end_empty", empty, 1);
    check("st_end_fill", fill, 0);
    tick();
    check("st_drain_valid", out_valid, 0);
    check("st_drain_b", b_rptr, 16);

    // advance to b_rptr=30, then wrap through 31,0,1,2
    g_wptr = 5'b10001;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (b_rptr == 5'd30) hit = 1'b1;
      else tick();
    end
    check("wr_reach30", b_rptr, 30);
    check("wr_g30", g_rptr, 5'b10001);
    g_wptr = 5'b00011;
    tick();
    check("wr_e1_valid", out_valid, 0);
    tick();
    check("wr_fill4", fill, 4);
    check("wr_ae4", almost_empty, 0);
    check("wr_em4", empty, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wr_b%0d", k), b_rptr, wr_b[k]);
      check($sformatf("wr_g%0d", k), g_rptr, wr_g[k]);
      check($sformatf("wr_d%0d", k), out_data, wr_d[k]);
      check($sformatf("wr_f%0d", k), fill, wr_f[k]);
      check($sformatf("wr_ae%0d", k), almost_empty,
            wr_ae[k]);
      check($sformatf("wr_em%0d", k), empty, wr_em[k]);
    end

    // backpressure with five words queued
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h50 + 8'(i);
    g_wptr = 5'b00111;
    tick();
    tick();
    check("bp_fill5", fill, 5);
    check("bp_valid0", out_valid, 0);
    for (int k = 0; k < 9; k++) begin
      out_ready = bp_r[k];
      tick();
      check($sformatf("bp_d%0d", k), out_data, bp_d[k]);
      check($sformatf("bp_f%0d", k), fill, bp_f[k]);
      check($sformatf("bp_v%0d", k), out_valid, bp_v[k]);
    end
    check("bp_end_b", b_rptr, 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
